line_buffer_window_gen: RTL and testbench
=========================================

LINE_BUFFER_WINDOW_GEN -- requirements
Module: line_buffer_window_gen

Interface
REQ-001 SHALL have parameter DATA_W, default 14, signed pixel width per channel.
REQ-002 SHALL have parameter CH, default 3, channel count (R,G,B packed channel 0 = LSBs).
REQ-003 SHALL have parameter IMG_W, default 224, pixels per row (>= 3).
REQ-004 SHALL have parameter IMG_H, default 224, rows per frame (>= 3).
REQ-005 SHALL have port clk  input  1  sole clock, rising edge.
REQ-006 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-007 SHALL have port in_pixel  input  CH*DATA_W  one pixel, all channels, raster order.
REQ-008 SHALL have port in_valid  input  1  in_pixel valid.
REQ-009 SHALL have port in_ready  output  1  block accepts in_pixel this cycle.
REQ-010 SHALL have port stride_sel  input  1  0 = stride 1, 1 = stride 2.
REQ-011 SHALL have port out_window  output  CH*9*DATA_W  3x3 window per channel.
REQ-012 SHALL have port out_valid  output  1  out_window valid.
REQ-013 SHALL have port out_ready  input  1  consumer accepts out_window.
REQ-014 SHALL have port frame_done  output  1  one-cycle pulse after last frame pixel accepted.

Function
REQ-015 Pixel accepted iff in_valid && in_ready; col/row counters advance only on acceptance, col wraps at IMG_W-1, row wraps at IMG_H-1.
REQ-016 Per channel, two line buffers of IMG_W entries plus a 3x3 register window shift on every accepted pixel; nothing shifts otherwise.
REQ-017 Window layout per channel: element (r,c) at slice index r*3+c, r=0 oldest row, c=0 leftmost column; channel k occupies bits [k*9*DATA_W +: 9*DATA_W].
REQ-018 Window whose bottom-right pixel is (row,col) SHALL be emitted iff row>=2, col>=2 and, with stride 2, (row-2) and (col-2) both even.
REQ-019 Windows straddling a row boundary (col<2) SHALL never be emitted.
REQ-020 out_valid SHALL rise the cycle after acceptance of the qualifying pixel (latency 1); out_window held stable while out_valid && !out_ready.
REQ-021 in_ready = !out_valid || out_ready (single output register, no bubble at full throughput).
REQ-022 stride_sel SHALL be sampled when pixel (0,0) is accepted and held for the whole frame; mid-frame changes ignored.
REQ-023 frame_done SHALL pulse the cycle after acceptance of pixel (IMG_H-1,IMG_W-1); counters return to (0,0); next frame's first window needs 2*IMG_W+3 pixels, no stale data used.
REQ-024 Data passes unmodified; no arithmetic on pixel values, signedness preserved.
REQ-025 Windows per frame: (IMG_H-2)*(IMG_W-2) for stride 1; ceil((IMG_H-2)/2)*ceil((IMG_W-2)/2) for stride 2.

Reset
REQ-026 On rst: out_valid=0, frame_done=0, out_window=0, counters=0, latched stride=0; in_ready=1 the cycle after rst deasserts.
REQ-027 Line buffer contents need not be cleared; REQ-018 gating guarantees no reset-era data is emitted.
REQ-028 rst mid-frame SHALL abort the frame; next accepted pixel is treated as (0,0).

Structure
REQ-029 Shared package holds KERNEL=3, window-slice index function and stride encoding constants.
REQ-030 One sub-module line_fifo (DATA_W*CH wide, IMG_W deep, shift-on-enable, circular-pointer RAM) instantiated twice.

Verification (bench: IMG_W=8, IMG_H=6; R=row*16+col, G=-R, B=R+100)
REQ-031 Stride 1, continuous valid, out_ready=1 -> first out_valid one cycle after 19th pixel, R window {0,1,2,16,17,18,32,33,34}, G negated, B +100; 24 windows, frame_done once.
REQ-032 Stride 2 -> 6 windows, origins (0,0),(0,2),(0,4),(2,0),(2,2),(2,4); first R window as REQ-031, second starts {2,3,4}.
REQ-033 out_ready=0 for 5 cycles during window (1,1) -> out_window stable, in_ready=0, no pixel lost; all 24 windows correct.
REQ-034 Toggle stride_sel mid-frame -> window count unchanged for that frame; new value applies from next (0,0).
REQ-035 rst after 30 pixels, then full frame -> out_valid stays 0 until 19th new pixel; 24 correct windows.
REQ-036 Two back-to-back frames with random in_valid gaps -> 48 windows, 2 frame_done pulses, no window mixes frames.

Source files
------------

// File: rtl/line_buffer_window_gen_pkg.sv
// Shared definitions for the 3x3 window generator.
//   KERNEL      : window edge length
//   WIN_ELEMS   : elements per channel window
//   stride_e    : stride_sel encoding (0 = every position, 1 = every other)
//   win_idx()   : slice index of element (r,c), r=0 oldest row, c=0 leftmost
package line_buffer_window_gen_pkg;

   localparam int unsigned KERNEL    = 3;
   localparam int unsigned WIN_ELEMS = KERNEL * KERNEL;

   typedef enum logic {
      STRIDE_1 = 1'b0,
      STRIDE_2 = 1'b1
   } stride_e;

   function automatic int unsigned win_idx(input int unsigned r, input int unsigned c);
      return r * KERNEL + c;
   endfunction

endpackage

// File: rtl/line_buffer_window_gen_line_fifo.sv
// Fixed-length delay line: dout is the word written DEPTH enables ago.
// Circular-pointer RAM; the read and write share one pointer, so each
// enable retires the oldest word and replaces it with din.
//   clk  : clock, rising edge
//   rst  : synchronous active-high, clears the pointer only
//   en   : shift enable
//   din  : word to store
//   dout : word stored DEPTH enables earlier
module line_fifo #(
   parameter int unsigned WIDTH = 42,
   parameter int unsigned DEPTH = 224
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    ptr;

   assign dout = mem[ptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr <= '0;
      end else if (en) begin
         ptr <= (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (en) begin
         mem[ptr] <= din;
      end
   end

endmodule

// File: rtl/line_buffer_window_gen.sv
// Streaming 3x3 window generator over a raster pixel stream.
//   clk, rst    : clock, synchronous active-high reset
//   in_pixel    : CH channels of DATA_W bits, channel 0 in the LSBs
//   in_valid    : in_pixel valid
//   in_ready    : pixel accepted this cycle when in_valid is also high
//   stride_sel  : 0 = stride 1, 1 = stride 2, latched at pixel (0,0)
//   out_window  : per channel 9 elements, element (r,c) at slice r*3+c
//   out_valid   : out_window valid, held until out_ready
//   out_ready   : consumer accepts out_window
//   frame_done  : one-cycle pulse after the last pixel of a frame
module line_buffer_window_gen
   import line_buffer_window_gen_pkg::*;
#(
   parameter int unsigned DATA_W = 14,
   parameter int unsigned CH     = 3,
   parameter int unsigned IMG_W  = 224,
   parameter int unsigned IMG_H  = 224
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [CH*DATA_W-1:0]          in_pixel,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic                          stride_sel,
   output logic [CH*WIN_ELEMS*DATA_W-1:0] out_window,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic                          frame_done
);

   localparam int unsigned PX_W  = CH * DATA_W;
   localparam int unsigned WIN_W = CH * WIN_ELEMS * DATA_W;
   localparam int unsigned CW    = $clog2(IMG_W);
   localparam int unsigned RW    = $clog2(IMG_H);

   logic [CW-1:0]    col;
   logic [RW-1:0]    row;
   stride_e          stride_q;
   logic             accept;
   logic             last_col;
   logic             last_row;
   logic             emit;
   logic [PX_W-1:0]  line0_out;
   logic [PX_W-1:0]  line1_out;
   logic [PX_W-1:0]  col_px [KERNEL];
   logic [WIN_W-1:0] win_q;
   logic [WIN_W-1:0] win_d;

   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready;
   assign last_col = (col == CW'(IMG_W - 1));
   assign last_row = (row == RW'(IMG_H - 1));

   // Odd row/col parity is equivalent to (row-2)/(col-2) being odd.
   // Gating on row>=2 also keeps stale line-buffer data out of the output.
   assign emit = accept && (row >= RW'(2)) && (col >= CW'(2)) &&
                 ((stride_q == STRIDE_1) || (!row[0] && !col[0]));

   line_fifo #(.WIDTH(PX_W), .DEPTH(IMG_W)) u_line0 (
      .clk  (clk),
      .rst  (rst),
      .en   (accept),
      .din  (in_pixel),
      .dout (line0_out)
   );

   line_fifo #(.WIDTH(PX_W), .DEPTH(IMG_W)) u_line1 (
      .clk  (clk),
      .rst  (rst),
      .en   (accept),
      .din  (line0_out),
      .dout (line1_out)
   );

   // Incoming column, oldest row first.
   assign col_px[0] = line1_out;
   assign col_px[1] = line0_out;
   assign col_px[2] = in_pixel;

   always_comb begin
      win_d = win_q;
      for (int unsigned k = 0; k < CH; k++) begin
         for (int unsigned r = 0; r < KERNEL; r++) begin
            for (int unsigned c = 0; c < KERNEL - 1; c++) begin
               win_d[(k*WIN_ELEMS + win_idx(r, c))*DATA_W +: DATA_W] =
                  win_q[(k*WIN_ELEMS + win_idx(r, c + 1))*DATA_W +: DATA_W];
            end
            win_d[(k*WIN_ELEMS + win_idx(r, KERNEL - 1))*DATA_W +: DATA_W] =
               col_px[r][k*DATA_W +: DATA_W];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         col        <= '0;
         row        <= '0;
         stride_q   <= STRIDE_1;
         win_q      <= '0;
         out_window <= '0;
         out_valid  <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= accept && last_col && last_row;
         if (accept) begin
            win_q <= win_d;
            if ((col == '0) && (row == '0)) begin
               stride_q <= stride_e'(stride_sel);
            end
            if (last_col) begin
               col <= '0;
               row <= last_row ? '0 : row + RW'(1);
            end else begin
               col <= col + CW'(1);
            end
            out_valid <= emit;
            if (emit) begin
               out_window <= win_d;
            end
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_line_buffer_window_gen.sv
module tb_line_buffer_window_gen;

   localparam int DW    = 14;
   localparam int CHN   = 3;
   localparam int W     = 8;
   localparam int H     = 6;
   localparam int PX_W  = CHN * DW;
   localparam int WIN_W = CHN * 9 * DW;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [PX_W-1:0]  in_pixel = '0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic             stride_sel = 1'b0;
   logic [WIN_W-1:0] out_window;
   logic             out_valid;
   logic             out_ready = 1'b1;
   logic             frame_done;

   line_buffer_window_gen #(
      .DATA_W (DW),
      .CH     (CHN),
      .IMG_W  (W),
      .IMG_H  (H)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .in_pixel   (in_pixel),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .stride_sel (stride_sel),
      .out_window (out_window),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   int tests  = 0;
   int failed = 0;

   // Reference model state
   int               m_row, m_col;
   bit               m_stride;
   bit               exp_valid, exp_fd;
   int               exp_br_r, exp_br_c;
   logic [WIN_W-1:0] exp_win;
   int               accepted = 0;

   // Observation counters
   int obs_wins, obs_fd, first_at, scen_acc0, stall_cycles;
   bit first_seen;

   function automatic logic [DW-1:0] chan(input int k, input int row, input int col);
      logic [DW-1:0] r;
      r = DW'(row * 16 + col);
      case (k)
         0:       return r;
         1:       return -r;
         default: return r + DW'(100);
      endcase
   endfunction

   function automatic logic [PX_W-1:0] pix(input int row, input int col);
      logic [PX_W-1:0] p;
      p = '0;
      for (int k = 0; k < CHN; k++) p[k*DW +: DW] = chan(k, row, col);
      return p;
   endfunction

   function automatic logic [WIN_W-1:0] build(input int row, input int col);
      logic [WIN_W-1:0] w;
      w = '0;
      for (int k = 0; k < CHN; k++)
         for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
               w[(k*9 + r*3 + c)*DW +: DW] = chan(k, row - 2 + r, col - 2 + c);
      return w;
   endfunction

   task automatic chk(input string tag, input logic [WIN_W-1:0] obs, input logic [WIN_W-1:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_row = 0; m_col = 0; m_stride = 0;
      exp_valid = 0; exp_fd = 0; exp_win = '0;
      exp_br_r = 0; exp_br_c = 0;
   endtask

   task automatic do_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      model_reset();
      @(negedge clk);
      chk("reset_out_valid",  WIN_W'(out_valid),  '0);
      chk("reset_frame_done", WIN_W'(frame_done), '0);
      chk("reset_out_window", out_window,         '0);
      chk("reset_in_ready",   WIN_W'(in_ready),   WIN_W'(1));
      @(posedge clk);
      #1;
   endtask

   task automatic start_scen();
      obs_wins = 0; obs_fd = 0; first_seen = 0; first_at = -1;
      stall_cycles = 0; scen_acc0 = accepted;
   endtask

   // One clock: drive, check outputs at the falling edge, advance the model.
   task automatic tick(input bit v, input bit ordy, input bit ssel);
      bit acc, emit;
      in_valid   = v;
      out_ready  = ordy;
      stride_sel = ssel;
      in_pixel   = v ? pix(m_row, m_col) : PX_W'({$urandom, $urandom});
      @(negedge clk);
      chk("out_valid",  WIN_W'(out_valid),  WIN_W'(exp_valid));
      chk("frame_done", WIN_W'(frame_done), WIN_W'(exp_fd));
      chk("in_ready",   WIN_W'(in_ready),   WIN_W'(!exp_valid || ordy));
      if (exp_valid) chk("out_window", out_window, exp_win);
      if (out_valid && out_ready) obs_wins++;
      if (frame_done) obs_fd++;
      if (out_valid && !ordy) stall_cycles++;
      if (out_valid && !first_seen) begin
         first_seen = 1;
         first_at = accepted - scen_acc0;
      end
      acc = v && (!exp_valid || ordy);
      exp_fd = 0;
      if (acc) begin
         if (m_row == 0 && m_col == 0) m_stride = ssel;
         emit = (m_row >= 2) && (m_col >= 2) &&
                (!m_stride || ((m_row % 2) == 0 && (m_col % 2) == 0));
         exp_valid = emit;
         if (emit) begin
            exp_win = build(m_row, m_col);
            exp_br_r = m_row; exp_br_c = m_col;
         end
         if (m_row == H - 1 && m_col == W - 1) exp_fd = 1;
         accepted++;
         if (m_col == W - 1) begin
            m_col = 0;
            m_row = (m_row == H - 1) ? 0 : m_row + 1;
         end else begin
            m_col++;
         end
      end else if (ordy) begin
         exp_valid = 0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic run_frame(input bit ssel, input bit gaps, input bit stall, input bit toggle);
      int start, stall_left, guard;
      bit stalled, v, ordy, s;
      start = accepted; stall_left = 0; guard = 0; stalled = 0;
      while ((accepted - start) < W * H && guard < 1000) begin
         v    = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
         ordy = 1'b1;
         s    = (toggle && (accepted - start) >= 20) ? !ssel : ssel;
         if (stall && !stalled && exp_valid && exp_br_r == 3 && exp_br_c == 3) begin
            stall_left = 5;
            stalled = 1;
         end
         if (stall_left > 0) begin
            ordy = 1'b0;
            stall_left--;
         end
         tick(v, ordy, s);
         guard++;
      end
      chk("frame_timeout", WIN_W'(guard < 1000), WIN_W'(1));
   endtask

   task automatic flush();
      repeat (4) tick(1'b0, 1'b1, 1'b0);
   endtask

   initial begin
      do_reset();

      // Stride 1, continuous
      start_scen();
      run_frame(1'b0, 1'b0, 1'b0, 1'b0);
      flush();
      chk("s1_first_at", WIN_W'(first_at), WIN_W'(19));
      chk("s1_windows",  WIN_W'(obs_wins), WIN_W'(24));
      chk("s1_frames",   WIN_W'(obs_fd),   WIN_W'(1));

      // Stride 2
      start_scen();
      run_frame(1'b1, 1'b0, 1'b0, 1'b0);
      flush();
      chk("s2_first_at", WIN_W'(first_at), WIN_W'(19));
      chk("s2_windows",  WIN_W'(obs_wins), WIN_W'(6));
      chk("s2_frames",   WIN_W'(obs_fd),   WIN_W'(1));

      // Back-pressure on window origin (1,1)
      start_scen();
      run_frame(1'b0, 1'b0, 1'b1, 1'b0);
      flush();
      chk("s3_stall_cycles", WIN_W'(stall_cycles), WIN_W'(5));
      chk("s3_windows",      WIN_W'(obs_wins),     WIN_W'(24));

      // stride_sel toggled mid-frame, then applied on the next frame
      start_scen();
      run_frame(1'b0, 1'b0, 1'b0, 1'b1);
      flush();
      chk("s4_toggle_windows", WIN_W'(obs_wins), WIN_W'(24));
      start_scen();
      run_frame(1'b1, 1'b0, 1'b0, 1'b0);
      flush();
      chk("s4_next_windows", WIN_W'(obs_wins), WIN_W'(6));

      // Reset after 30 pixels, then a full frame
      repeat (30) tick(1'b1, 1'b1, 1'b0);
      do_reset();
      start_scen();
      run_frame(1'b0, 1'b0, 1'b0, 1'b0);
      flush();
      chk("s5_first_at", WIN_W'(first_at), WIN_W'(19));
      chk("s5_windows",  WIN_W'(obs_wins), WIN_W'(24));
      chk("s5_frames",   WIN_W'(obs_fd),   WIN_W'(1));

      // Two frames back to back with random input gaps
      start_scen();
      run_frame(1'b0, 1'b1, 1'b0, 1'b0);
      run_frame(1'b0, 1'b1, 1'b0, 1'b0);
      flush();
      chk("s6_windows", WIN_W'(obs_wins), WIN_W'(48));
      chk("s6_frames",  WIN_W'(obs_fd),   WIN_W'(2));

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
